// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I core: machine word width, the canonical
// NOP encoding, the instruction-memory FSM state type and the fetch response
// record carried through the read pipeline.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_t;

  typedef struct packed {
    logic            valid;
    logic            fault;
    logic [XLEN-1:0] data;
  } fetch_resp_t;

endpackage : rv32i_pkg

// File: rtl/fetch_resp_pipe.sv
// ---------------------------------------------------------------------------
// fetch_resp_pipe
// LATENCY-stage shift register of {valid, fault, data} fetch responses.
// Stage 0 is loaded from the inputs, the output is the last stage.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   flush_i                   clears every valid bit, including the entry
//                             being loaded this cycle
//   in_valid_i/in_fault_i/in_data_i     response entering stage 0
//   out_valid_o/out_fault_o/out_data_o  last stage
// ---------------------------------------------------------------------------
module fetch_resp_pipe
  import rv32i_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  input  logic            in_fault_i,
  input  logic [XLEN-1:0] in_data_i,
  output logic            out_valid_o,
  output logic            out_fault_o,
  output logic [XLEN-1:0] out_data_o
);

  fetch_resp_t [LATENCY-1:0] stage_q, stage_d;

  // Payload fields only move along with a valid bit; a bubble or a flush
  // leaves them untouched, so the output stage keeps showing the last
  // delivered response while valid is low.
  always_comb begin
    stage_d = stage_q;

    stage_d[0].valid = in_valid_i & ~flush_i;
    if (in_valid_i && !flush_i) begin
      stage_d[0].fault = in_fault_i;
      stage_d[0].data  = in_data_i;
    end

    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i].valid = stage_q[i-1].valid & ~flush_i;
      if (stage_q[i-1].valid && !flush_i) begin
        stage_d[i].fault = stage_q[i-1].fault;
        stage_d[i].data  = stage_q[i-1].data;
      end
    end
  end

  // NOTE: state flops take non-blocking assignments only, so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid_o = stage_q[LATENCY-1].valid;
  assign out_fault_o = stage_q[LATENCY-1].fault;
  assign out_data_o  = stage_q[LATENCY-1].data;

endmodule : fetch_resp_pipe

// File: rtl/imem_fetch_port.sv
// ---------------------------------------------------------------------------
// imem_fetch_port
// Loadable instruction memory for the RV32I fetch stage. After reset it is in
// LOAD and accepts program words; after load_done_i it serves byte-addressed
// fetches with a fixed LATENCY, flush support and fault reporting.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   load_en_i/load_addr_i/load_data_i   word write port (LOAD and RUN)
//   load_done_i               pulse: LOAD -> RUN
//   req_i/addr_i/ready_o      fetch request handshake (byte address)
//   flush_i                   drop every in-flight response
//   valid_o/instruction_o/fault_o       response, LATENCY cycles after accept
// ---------------------------------------------------------------------------
module imem_fetch_port
  import rv32i_pkg::*;
#(
  parameter int              DEPTH    = 256,
  parameter int              LATENCY  = 1,
  parameter logic [XLEN-1:0] NOP_WORD = RV32I_NOP
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [XLEN-1:0]          load_data_i,
  input  logic                     load_done_i,
  input  logic                     req_i,
  input  logic [XLEN-1:0]          addr_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          instruction_o,
  output logic                     fault_o
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  imem_state_t     state_q, state_d;

  logic            accept;
  logic [AW-1:0]   word_idx;
  logic            fetch_fault;
  logic [XLEN-1:0] fetch_data;

  // ---------------------------------------------------------------- memory
  // NOTE: the program store has no reset on purpose: contents survive a core
  // reset, and a reset on a large array would block RAM inference.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IMEM_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each combinational output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IMEM_LOAD: if (load_done_i) state_d = IMEM_RUN;
      IMEM_RUN:  state_d = IMEM_RUN;  // only reset leaves RUN
      default:   state_d = IMEM_LOAD;
    endcase
  end

  // A patch write in RUN owns the cycle, so fetch is stalled while it lands.
  // This also rules out read-during-write on the array.
  always_comb begin
    ready_o = 1'b0;
    if (state_q == IMEM_RUN) begin
      ready_o = ~load_en_i;
    end
  end

  // ------------------------------------------------------------ fetch path
  // Any set bit above the word index means the address is past the end of
  // the array; the index is never wrapped.
  always_comb begin
    accept      = req_i & ready_o;
    word_idx    = addr_i[2 +: AW];
    fetch_fault = (|addr_i[1:0]) | (|addr_i[XLEN-1:2+AW]);
    fetch_data  = fetch_fault ? NOP_WORD : mem_q[word_idx];
  end

  // The array is read at acceptance, so a later write to the same word
  // cannot change a response already in the pipe.
  fetch_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (accept),
    .in_fault_i  (fetch_fault),
    .in_data_i   (fetch_data),
    .out_valid_o (valid_o),
    .out_fault_o (fault_o),
    .out_data_o  (instruction_o)
  );

endmodule : imem_fetch_port

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i;
  logic        reset_i;
  logic        load_en_i;
  logic [7:0]  load_addr_i;
  logic [31:0] load_data_i;
  logic        load_done_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic        ready_o;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic        fault_o;

  int total = 0;
  int bad   = 0;

  imem_fetch_port #(
    .DEPTH    (DEPTH),
    .LATENCY  (LAT),
    .NOP_WORD (NOP)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .load_en_i     (load_en_i),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
    .load_done_i   (load_done_i),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .instruction_o (instruction_o),
    .fault_o       (fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move to 1 ns after the next rising edge; inputs are driven and registered
  // outputs sampled there, well away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    load_en_i   = 1'b0;
    load_addr_i = '0;
    load_data_i = '0;
    load_done_i = 1'b0;
    req_i       = 1'b0;
    addr_i      = '0;
    flush_i     = 1'b0;
  endtask

  // Issue one request this cycle and capture the response LAT cycles later.
  task automatic fetch_one(input logic [31:0] a, output logic v, output logic f,
                           output logic [31:0] d);
    req_i  = 1'b1;
    addr_i = a;
    step();
    req_i  = 1'b0;
    repeat (LAT - 1) step();
    v = valid_o;
    f = fault_o;
    d = instruction_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle_inputs();
    repeat (2) step();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault_o); end
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", instruction_o); end
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_load_ignores_req();
    req_i  = 1'b1;
    addr_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL load_ready cyc%0d: got %b want 0", i, ready_o); end
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL load_valid cyc%0d: got %b want 0", i, valid_o); end
      step();
    end
    req_i = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      load_en_i   = 1'b1;
      load_addr_i = 8'(i);
      load_data_i = 32'h1111_1111 * (i + 1);
      step();
    end
    load_en_i   = 1'b0;
    load_done_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL done_cycle_ready: got %b want 0", ready_o); end
    step();
    load_done_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL run_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int n;
    for (int k = 0; k < 4 + LAT; k++) begin
      if (k < 4) begin
        req_i  = 1'b1;
        addr_i = 32'(k * 4);
      end else begin
        req_i = 1'b0;
      end
      step();
      n = k + 1 - LAT;
      if (n >= 0 && n < 4) begin
        exp = 32'h1111_1111 * (n + 1);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", n, valid_o); end
        total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL b2b_fault[%0d]: got %b want 0", n, fault_o); end
        total++; if (instruction_o !== exp) begin bad++; $display("FAIL b2b_instr[%0d]: got %h want %h", n, instruction_o, exp); end
      end else begin
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle k%0d: valid got %b want 0", k, valid_o); end
      end
    end
    total++; if (instruction_o !== 32'h4444_4444) begin bad++; $display("FAIL b2b_hold: got %h want 44444444", instruction_o); end
  endtask

  task automatic test_fault();
    logic v, f;
    logic [31:0] d;
    logic [31:0] addrs [5] = '{32'h0000_0006, 32'h0000_0400, 32'h8000_0000,
                               32'h0000_000C, 32'h0000_03FC};
    logic        exp_f [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      fetch_one(addrs[i], v, f, d);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL fault_valid @%h: got %b want 1", addrs[i], v); end
      total++; if (f !== exp_f[i]) begin bad++; $display("FAIL fault_flag @%h: got %b want %b", addrs[i], f, exp_f[i]); end
      if (exp_f[i]) begin
        total++; if (d !== NOP) begin bad++; $display("FAIL fault_nop @%h: got %h want %h", addrs[i], d, NOP); end
      end else if (i == 3) begin
        total++; if (d !== 32'h4444_4444) begin bad++; $display("FAIL fault_ok_data @%h: got %h want 44444444", addrs[i], d); end
      end
    end
    step();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      req_i   = 1'b1;
      addr_i  = 32'(k * 4);
      flush_i = (k == 2);
      step();
    end
    flush_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_c3: valid got %b want 0", valid_o); end
    addr_i = 32'h8;
    step();
    req_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_c4: valid got %b want 0", valid_o); end
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_c5: valid got %b want 0", valid_o); end
    step();
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL flush_after_valid: got %b want 1", valid_o); end
    total++; if (instruction_o !== 32'h3333_3333) begin bad++; $display("FAIL flush_after_instr: got %h want 33333333", instruction_o); end
    step();
  endtask

  task automatic test_patch();
    logic v, f;
    logic [31:0] d;
    load_en_i   = 1'b1;
    load_addr_i = 8'd1;
    load_data_i = 32'hDEAD_BEEF;
    req_i       = 1'b1;
    addr_i      = 32'h4;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL patch_ready: got %b want 0", ready_o); end
    step();
    load_en_i = 1'b0;
    req_i     = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (i > 0) step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL patch_no_resp %0d: valid got %b want 0", i, valid_o); end
    end
    fetch_one(32'h4, v, f, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL patch_retry_valid: got %b want 1", v); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL patch_retry_instr: got %h want deadbeef", d); end
    step();
  endtask

  task automatic test_reset_midflight();
    logic v, f;
    logic [31:0] d;
    req_i  = 1'b1;
    addr_i = 32'h0;
    step();
    addr_i = 32'h4;
    step();
    req_i = 1'b0;
    step();
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", valid_o); end
    total++; if (instruction_o !== 32'h1111_1111) begin bad++; $display("FAIL mid_pre_instr: got %h want 11111111", instruction_o); end
    #2;
    reset_i = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", valid_o); end
    total++; if (instruction_o !== 32'h0) begin bad++; $display("FAIL mid_async_instr: got %h want 00000000", instruction_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_async_ready: got %b want 0", ready_o); end
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_lost %0d: valid got %b want 0", i, valid_o); end
    end
    load_done_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_back_in_load: ready got %b want 0", ready_o); end
    step();
    load_done_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mid_run_ready: got %b want 1", ready_o); end
    fetch_one(32'h0, v, f, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL mid_retained_valid: got %b want 1", v); end
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL mid_retained_instr: got %h want 11111111", d); end
  endtask

  initial begin
    test_reset();
    test_load_ignores_req();
    test_load();
    test_back_to_back();
    test_fault();
    test_flush();
    test_patch();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_fetch_port
